qtree_nat_serializer: RTL and testbench

- Downstream stage of the mMapKron kernel wrapper: accepts the result root pointer (Pointer_QTree_Nat) from the kernel.
- Walks the QTree_Nat structure in node memory through a single-outstanding read port.
- Emits the tree as an AXI-stream in postfix order (children q0..q3, then parent), tlast on the root beat.
- Mirror of the input deserializer: a consumer can rebuild the tree with a stack by popping 4 entries on each QNode.

---
 rtl/qtree_nat_serializer.sv | 184 ++++++++++++++++++
 tb/tb_qtree_nat_serializer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qtree_nat_serializer.sv
// qtree_nat_serializer
//   Walks a QTree_Nat held in node memory, starting from a root pointer, and
//   streams it out in postfix order: children q0..q3 first, then the parent.
//   A QNode goes out as a tag-only word, so a consumer can rebuild the tree
//   with a stack by popping four entries whenever it sees a QNode. The root
//   beat carries o_tlast.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   root_*          root pointer handshake (accepted only in IDLE)
//   rd_req_*        node read request, at most one outstanding
//   rd_resp_*       read response, exactly one per accepted request
//   o_t*            AXI-stream output, one beat buffered at most
//   overflow        sticky flag: a QNode was nested deeper than DEPTH
module qtree_nat_serializer #(
  parameter int PTR_W  = 16,
  parameter int NODE_W = 66,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              root_valid,
  output logic              root_ready,
  input  logic [PTR_W-1:0]  root_ptr,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [PTR_W-1:0]  rd_addr,
  input  logic              rd_resp_valid,
  input  logic [NODE_W-1:0] rd_resp_data,
  output logic [NODE_W-1:0] o_tdata,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic              o_tlast,
  output logic              overflow
);

  localparam int SP_W  = $clog2(DEPTH) + 1;
  localparam int IX_W  = $clog2(DEPTH);
  localparam int ENT_W = NODE_W + 3;

  localparam logic [1:0] TAG_QNODE = 2'd2;
  localparam logic [NODE_W-1:0] QNODE_WORD = {{(NODE_W-2){1'b0}}, 2'd2};
  localparam logic [NODE_W-1:0] QERR_WORD  = {{(NODE_W-2){1'b0}}, 2'd3};

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_WAIT, ST_NEXT, ST_EMIT, ST_ABORT
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    addr_q, addr_d;
  logic [NODE_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                ovf_q, ovf_d;

  // Stack entry = {node word, next child index 0..4}
  logic [ENT_W-1:0]    stack_mem_q [DEPTH];
  logic                stack_we;
  logic [IX_W-1:0]     stack_waddr;
  logic [ENT_W-1:0]    stack_wdata;

  logic [IX_W-1:0]     top_ix;
  logic [ENT_W-1:0]    top_ent;
  logic [NODE_W-1:0]   top_word;
  logic [2:0]          top_cidx;
  logic [PTR_W-1:0]    child_ptr;
  logic                stack_full;

  assign top_ix     = IX_W'(sp_q - SP_W'(1));
  assign top_ent    = stack_mem_q[top_ix];
  assign top_word   = top_ent[ENT_W-1:3];
  assign top_cidx   = top_ent[2:0];
  // Only evaluated while top_cidx < 4, so the low two bits select the child.
  assign child_ptr  = top_word[2 + PTR_W*top_cidx[1:0] +: PTR_W];
  assign stack_full = (sp_q == SP_W'(DEPTH));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      sp_q       <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      sp_q       <= sp_d;
      ovf_q      <= ovf_d;
    end
  end

  // Stack storage holds data only; validity is tracked by sp_q.
  always_ff @(posedge clk) begin
    if (stack_we) stack_mem_q[stack_waddr] <= stack_wdata;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (root_valid) state_d = ST_REQ;
      ST_REQ:   if (rd_req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (rd_resp_valid) begin
          if (rd_resp_data[1:0] == TAG_QNODE) state_d = stack_full ? ST_ABORT : ST_NEXT;
          else                                state_d = ST_EMIT;
        end
      end
      ST_NEXT:  state_d = (top_cidx < 3'd4) ? ST_REQ : ST_EMIT;
      ST_EMIT:  if (o_tready) state_d = out_last_q ? ST_IDLE : ST_NEXT;
      ST_ABORT: state_d = ST_EMIT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath / stack updates
  always_comb begin
    addr_d      = addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    sp_d        = sp_q;
    ovf_d       = ovf_q;
    stack_we    = 1'b0;
    stack_waddr = top_ix;
    stack_wdata = {top_word, 3'(top_cidx + 3'd1)};
    case (state_q)
      ST_IDLE: if (root_valid) addr_d = root_ptr;
      ST_WAIT: begin
        if (rd_resp_valid) begin
          if (rd_resp_data[1:0] == TAG_QNODE) begin
            if (stack_full) begin
              ovf_d = 1'b1;
            end else begin
              stack_we    = 1'b1;
              stack_waddr = sp_q[IX_W-1:0];
              stack_wdata = {rd_resp_data, 3'd0};
              sp_d        = sp_q + SP_W'(1);
            end
          end else begin
            // Leaf goes out verbatim; it is the root only if nothing is stacked.
            out_data_d = rd_resp_data;
            out_last_d = (sp_q == '0);
          end
        end
      end
      ST_NEXT: begin
        if (top_cidx < 3'd4) begin
          addr_d   = child_ptr;
          stack_we = 1'b1;
        end else begin
          sp_d       = sp_q - SP_W'(1);
          out_data_d = QNODE_WORD;
          out_last_d = (sp_q == SP_W'(1));
        end
      end
      ST_ABORT: begin
        out_data_d = QERR_WORD;
        out_last_d = 1'b1;
        sp_d       = '0;
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    root_ready   = (state_q == ST_IDLE) && !reset;
    rd_req_valid = (state_q == ST_REQ);
    o_tvalid     = (state_q == ST_EMIT);
    rd_addr      = addr_q;
    o_tdata      = out_data_q;
    o_tlast      = out_last_q;
    overflow     = ovf_q;
  end

  // NEXT is only reached with at least one QNode on the stack.
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_NEXT) |-> (sp_q != '0));

endmodule

// File: tb/tb_qtree_nat_serializer.sv
// Testbench for qtree_nat_serializer: node memory model with single-cycle
// responses, random request/stream backpressure, and a recursive postfix
// reference walk of the tree to produce expected beats and read addresses.
module tb_qtree_nat_serializer;
  localparam int PTR_W    = 16;
  localparam int NODE_W   = 66;
  localparam int TB_DEPTH = 2;
  localparam logic [NODE_W-1:0] QNODE_BEAT = NODE_W'(2);
  localparam logic [NODE_W-1:0] QERR_BEAT  = NODE_W'(3);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              root_valid = 1'b0;
  logic              root_ready;
  logic [PTR_W-1:0]  root_ptr = '0;
  logic              rd_req_valid;
  logic              rd_req_ready = 1'b0;
  logic [PTR_W-1:0]  rd_addr;
  logic              rd_resp_valid = 1'b0;
  logic [NODE_W-1:0] rd_resp_data = '0;
  logic [NODE_W-1:0] o_tdata;
  logic              o_tvalid;
  logic              o_tready = 1'b0;
  logic              o_tlast;
  logic              overflow;

  qtree_nat_serializer #(.PTR_W(PTR_W), .NODE_W(NODE_W), .DEPTH(TB_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .root_valid(root_valid), .root_ready(root_ready), .root_ptr(root_ptr),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tlast(o_tlast),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [NODE_W-1:0] mem [256];
  logic [NODE_W:0]   got_beats[$], exp_beats[$];
  logic [PTR_W-1:0]  got_addr[$], exp_addr[$];
  int  n_last = 0;
  int  first_v_cyc = -1;
  int  acc_cyc = 0;
  int  alloc = 0;
  bit  bp = 0;
  bit  hold_tready = 0;
  bit  m_abort = 0;
  bit  m_ovf = 0;

  // Memory responder: response one cycle after each accepted request.
  bit               pend = 0;
  logic [PTR_W-1:0] pend_addr = '0;
  bit               req_stall = 0;
  logic [PTR_W-1:0] stall_addr = '0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      pend = 0; req_stall = 0;
      rd_resp_valid = 1'b0; rd_req_ready = 1'b0;
    end else begin
      if (pend) begin
        rd_resp_valid = 1'b1;
        rd_resp_data  = mem[pend_addr[7:0]];
        pend = 0;
      end else begin
        rd_resp_valid = 1'b0;
        rd_resp_data  = NODE_W'({$urandom(), $urandom(), $urandom()});
      end
      if (req_stall)
        check_eq("req_hold", 128'({rd_req_valid, rd_addr}), 128'({1'b1, stall_addr}));
      rd_req_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rd_req_valid && rd_req_ready) begin
        pend = 1; pend_addr = rd_addr;
        got_addr.push_back(rd_addr);
      end
      req_stall  = rd_req_valid && !rd_req_ready;
      stall_addr = rd_addr;
    end
  end

  // Stream sink with optional 1-in-3 readiness.
  bit              prev_stall = 0;
  logic [NODE_W:0] prev_beat = '0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      o_tready = 1'b0; prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check_eq("tvalid_hold", 128'(o_tvalid), 128'(1));
        check_eq("tdata_hold", 128'({o_tlast, o_tdata}), 128'(prev_beat));
      end
      if (o_tvalid && first_v_cyc < 0) first_v_cyc = cyc;
      o_tready = hold_tready ? 1'b0 : (bp ? ($urandom_range(0, 2) == 0) : 1'b1);
      if (o_tvalid && o_tready) begin
        got_beats.push_back({o_tlast, o_tdata});
        if (o_tlast) n_last++;
      end
      prev_stall = o_tvalid && !o_tready;
      prev_beat  = {o_tlast, o_tdata};
    end
  end

  function automatic logic [NODE_W-1:0] mknode(input logic [PTR_W-1:0] c0, c1, c2, c3);
    logic [NODE_W-1:0] w;
    w = {c3, c2, c1, c0, 2'd2};
    return w;
  endfunction

  function automatic logic [NODE_W-1:0] mkleaf(input logic [1:0] tag, input logic [PTR_W-1:0] v);
    logic [NODE_W-1:0] w;
    w = '0;
    w[1:0] = tag;
    w[2 +: PTR_W] = v;
    return w;
  endfunction

  // Random tree generator; lvl = number of QNode ancestors.
  function automatic logic [PTR_W-1:0] build(input int lvl);
    int a;
    int p;
    int t;
    logic [PTR_W-1:0] c [4];
    logic [NODE_W-1:0] w;
    a = alloc;
    alloc++;
    p = $urandom_range(0, 99);
    if ((lvl < 2 && p < 30) || (lvl == 2 && p < 10)) begin
      for (int k = 0; k < 4; k++) c[k] = build(lvl + 1);
      w = mknode(c[0], c[1], c[2], c[3]);
    end else begin
      w = NODE_W'({$urandom(), $urandom(), $urandom()});
      t = $urandom_range(0, 2);
      w[1:0] = (t == 2) ? 2'd3 : 2'(t);
    end
    mem[a] = w;
    return PTR_W'(a);
  endfunction

  // Reference: recursive postfix walk with a depth limit of TB_DEPTH QNodes.
  function automatic void walk(input logic [PTR_W-1:0] a, input int lvl);
    logic [NODE_W-1:0] w;
    if (m_abort) return;
    exp_addr.push_back(a);
    w = mem[a[7:0]];
    if (w[1:0] == 2'd2) begin
      if (lvl >= TB_DEPTH) begin
        m_abort = 1; m_ovf = 1;
        exp_beats.push_back({1'b1, QERR_BEAT});
        return;
      end
      for (int k = 0; k < 4; k++) begin
        walk(w[2 + PTR_W*k +: PTR_W], lvl + 1);
        if (m_abort) return;
      end
      exp_beats.push_back({1'b0, QNODE_BEAT});
    end else begin
      exp_beats.push_back({1'b0, w});
    end
  endfunction

  task automatic send_root(input logic [PTR_W-1:0] p);
    int n;
    n = 0;
    @(negedge clk);
    root_valid = 1'b1; root_ptr = p; first_v_cyc = -1;
    while (!root_ready && n < 200) begin @(negedge clk); n++; end
    check_eq("root_accept", 128'(root_ready), 128'(1));
    @(posedge clk); #1;
    acc_cyc = cyc;
    @(negedge clk);
    root_valid = 1'b0; root_ptr = PTR_W'($urandom());
  endtask

  task automatic run_tree(input logic [PTR_W-1:0] root, input string tag);
    int n;
    logic [NODE_W:0] tmp;
    exp_beats.delete(); exp_addr.delete();
    got_beats.delete(); got_addr.delete();
    m_abort = 0;
    walk(root, 0);
    if (!m_abort) begin
      tmp = exp_beats[$]; tmp[NODE_W] = 1'b1; exp_beats[$] = tmp;
    end
    n = n_last;
    send_root(root);
    for (int i = 0; i < 4000 && n_last == n; i++) @(negedge clk);
    check_eq($sformatf("%s_done", tag), 128'(n_last != n), 128'(1));
    check_eq($sformatf("%s_nbeats", tag), 128'(got_beats.size()), 128'(exp_beats.size()));
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++)
      check_eq($sformatf("%s_beat%0d", tag, i), 128'(got_beats[i]), 128'(exp_beats[i]));
    check_eq($sformatf("%s_nreads", tag), 128'(got_addr.size()), 128'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      check_eq($sformatf("%s_addr%0d", tag, i), 128'(got_addr[i]), 128'(exp_addr[i]));
    @(negedge clk); @(negedge clk);
    check_eq($sformatf("%s_idle_ready", tag), 128'(root_ready), 128'(1));
    check_eq($sformatf("%s_overflow", tag), 128'(overflow), 128'(m_ovf));
  endtask

  initial begin
    logic [PTR_W-1:0] r;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    // Fixed trees
    mem[5] = mkleaf(2'd1, 16'd7);
    mem[1] = mknode(16'd2, 16'd3, 16'd4, 16'd5);
    mem[2] = mkleaf(2'd1, 16'd10);
    mem[3] = mkleaf(2'd1, 16'd11);
    mem[4] = mkleaf(2'd1, 16'd12);
    mem[20] = mknode(16'd21, 16'd22, 16'd27, 16'd28);
    mem[21] = mkleaf(2'd1, 16'd1);
    mem[22] = mknode(16'd23, 16'd24, 16'd25, 16'd26);
    mem[27] = mkleaf(2'd1, 16'd3);
    mem[28] = mkleaf(2'd3, 16'd0);
    mem[40] = mknode(16'd41, 16'd50, 16'd50, 16'd50);
    mem[41] = mknode(16'd42, 16'd50, 16'd50, 16'd50);
    mem[42] = mknode(16'd43, 16'd50, 16'd50, 16'd50);
    mem[43] = mkleaf(2'd1, 16'd99);
    mem[50] = mkleaf(2'd1, 16'd55);

    repeat (3) @(negedge clk);
    check_eq("rst_root_ready", 128'(root_ready), 128'(0));
    check_eq("rst_outputs", 128'({rd_req_valid, o_tvalid, o_tlast, overflow}), 128'(0));
    check_eq("rst_rd_addr", 128'(rd_addr), 128'(0));
    check_eq("rst_tdata", 128'(o_tdata), 128'(0));
    reset = 1'b0; m_ovf = 0;
    @(negedge clk);
    check_eq("idle_root_ready", 128'(root_ready), 128'(1));

    bp = 0;
    run_tree(16'd5, "leaf");
    check_eq("leaf_latency", 128'(first_v_cyc - acc_cyc), 128'(2));
    run_tree(16'd1, "qnode1");
    run_tree(16'd20, "twolvl");
    bp = 1;
    run_tree(16'd20, "twolvl_bp");
    bp = 0;
    run_tree(16'd40, "ovf");
    run_tree(16'd1, "after_ovf");

    // Reset while a beat is stalled in EMIT
    hold_tready = 1;
    send_root(16'd1);
    for (int i = 0; i < 200 && !o_tvalid; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("stall_tvalid", 128'(o_tvalid), 128'(1));
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_tvalid", 128'(o_tvalid), 128'(0));
    check_eq("midrst_overflow", 128'(overflow), 128'(0));
    m_ovf = 0;
    reset = 1'b0; hold_tready = 0;
    @(negedge clk);
    check_eq("midrst_root_ready", 128'(root_ready), 128'(1));
    run_tree(16'd20, "post_rst");

    for (int t = 0; t < 25; t++) begin
      alloc = 60;
      r = build(0);
      bp = ($urandom_range(0, 1) == 1);
      run_tree(r, $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
